rr_arbiter_n: RTL



---
 rtl/rr_arbiter_n.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// N-input registered round-robin arbiter with a one-entry output stage.
// Optional burst locking is compiled in with `define ARB_LOCK_EN.

module rr_arbiter_n_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             eligible,
  input  logic [SEL_W-1:0] last_grant,
  output logic             req_lo,
  output logic             req_hi
);
  localparam logic [SEL_W-1:0] IDX_S = SEL_W'(IDX);

  // req_hi marks requesters strictly above the last grant; they win before any wrap
  assign req_lo = valid & eligible;
  assign req_hi = req_lo & (IDX_S > last_grant);
endmodule

module rr_arbiter_n #(
  parameter int NUM_IN = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        io_in_valid,
  output logic [NUM_IN-1:0]        io_in_ready,
  input  logic [NUM_IN-1:0]        io_in_rw,
  input  logic [NUM_IN*ADDR_W-1:0] io_in_addr,
  input  logic [NUM_IN*DATA_W-1:0] io_in_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_IN-1:0]        io_in_lock,
`endif
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic                     io_out_bits_rw,
  output logic [ADDR_W-1:0]        io_out_bits_addr,
  output logic [DATA_W-1:0]        io_out_bits_data,
  output logic [SEL_W-1:0]         io_chosen
);
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0]  last_grant;
  logic [NUM_IN-1:0] eligible, req_lo, req_hi;
  logic [SEL_W-1:0]  win_idx;
  logic              win_ok, can_load, xfer;
  req_t              win_req, out_q;

`ifdef ARB_LOCK_EN
  logic             lock_active;
  logic [SEL_W-1:0] lock_ch;

  always_comb begin
    eligible = '1;
    if (lock_active) begin
      for (int i = 0; i < NUM_IN; i++) eligible[i] = (lock_ch == SEL_W'(i));
    end
  end
`else
  assign eligible = '1;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    rr_arbiter_n_lane #(.SEL_W(SEL_W), .IDX(g)) u_lane (
      .valid      (io_in_valid[g]),
      .eligible   (eligible[g]),
      .last_grant (last_grant),
      .req_lo     (req_lo[g]),
      .req_hi     (req_hi[g])
    );
  end

  // Lowest set bit of req_hi if any, otherwise lowest of req_lo (the wrapped half)
  always_comb begin
    win_idx = '0;
    win_ok  = |req_lo;
    for (int i = NUM_IN - 1; i >= 0; i--) if (req_lo[i]) win_idx = SEL_W'(i);
    for (int i = NUM_IN - 1; i >= 0; i--) if (req_hi[i]) win_idx = SEL_W'(i);
  end

  assign can_load = !io_out_valid | io_out_ready;
  assign xfer     = can_load & win_ok & !reset;

  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) io_in_ready[i] = xfer & (win_idx == SEL_W'(i));
  end

  always_comb begin
    win_req.rw   = io_in_rw[win_idx];
    win_req.addr = io_in_addr[win_idx*ADDR_W +: ADDR_W];
    win_req.data = io_in_data[win_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      out_q        <= '0;
      io_chosen    <= '0;
      last_grant   <= LAST_RST;
    end else if (xfer) begin
      io_out_valid <= 1'b1;
      out_q        <= win_req;
      io_chosen    <= win_idx;
      last_grant   <= win_idx;
    end else if (io_out_valid & io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

`ifdef ARB_LOCK_EN
  // While locked only lock_ch can win, so every transfer re-evaluates the lock bit
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_ch     <= '0;
    end else if (xfer) begin
      lock_active <= io_in_lock[win_idx];
      lock_ch     <= win_idx;
    end
  end
`endif

  assign io_out_bits_rw   = out_q.rw;
  assign io_out_bits_addr = out_q.addr;
  assign io_out_bits_data = out_q.data;
endmodule
